pe_acc_drain: RTL and testbench

- Read-side counterpart to the PE row: on a `start` pulse it snapshots the acc1/acc2 accumulators of N_PE processing elements.
- It then streams the snapshot one word per handshake on a valid/ready output toward the attention result buffer.
- It pulses `pe_clear` so the PEs can begin the next accumulation while draining continues.

---
 rtl/pe_acc_drain.sv | 90 +++++++++
 tb/tb_pe_acc_drain.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_acc_drain.sv
// rtl/pe_acc_drain.sv - snapshots PE acc1/acc2 accumulators and streams them out one word per handshake
module pe_acc_drain #(
    parameter int WIDTH = 8,
    parameter int N_PE  = 4,
    parameter int IDX_W = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N_PE*2*WIDTH-1:0]   acc1_bus,
    input  logic [N_PE*2*WIDTH-1:0]   acc2_bus,
    output logic                      pe_clear,
    output logic [2*WIDTH-1:0]        out_data,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      overrun
);

    localparam int AW = 2 * WIDTH;
    localparam int NW = 2 * N_PE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state, nxt_state;
    logic [IDX_W-1:0] idx, nxt_idx;
    logic             nxt_clear, nxt_overrun;
    logic             capture, xfer, done;
    logic [AW-1:0]    snap [NW];

    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign out_idx   = idx;
    assign out_last  = out_valid && (idx == LAST_IDX);
    assign out_data  = snap[idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            pe_clear <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= nxt_state;
            idx      <= nxt_idx;
            pe_clear <= nxt_clear;
            overrun  <= nxt_overrun;
        end
    end

    // A start on the edge carrying the final transfer is taken back-to-back; any other start while busy is dropped.
    always_comb begin
        nxt_state   = state;
        nxt_idx     = idx;
        nxt_clear   = 1'b0;
        nxt_overrun = overrun;
        xfer        = out_valid && out_ready;
        done        = xfer && out_last;
        capture     = start && ((state == IDLE) || done);
        if (capture) begin
            nxt_state = STREAM;
            nxt_idx   = '0;
            nxt_clear = 1'b1;
        end else if (done) begin
            nxt_state = IDLE;
            nxt_idx   = '0;
        end else if (xfer) begin
            nxt_idx   = idx + 1'b1;
        end
        if (start && !capture)
            nxt_overrun = 1'b1;
    end

    // Even word index holds acc1, odd holds acc2 of PE idx/2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NW; i++)
                snap[i] <= '0;
        end else if (capture) begin
            for (int p = 0; p < N_PE; p++) begin
                snap[2*p]     <= acc1_bus[p*AW +: AW];
                snap[2*p + 1] <= acc2_bus[p*AW +: AW];
            end
        end
    end

endmodule

// File: tb/tb_pe_acc_drain.sv
// tb/tb_pe_acc_drain.sv - self-checking bench for pe_acc_drain against a word-list reference model
module tb_pe_acc_drain;

    localparam int WIDTH = 8;
    localparam int N_PE  = 4;
    localparam int IDX_W = 3;
    localparam int NW    = 2 * N_PE;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic [N_PE*2*WIDTH-1:0] acc1_bus;
    logic [N_PE*2*WIDTH-1:0] acc2_bus;
    logic                    pe_clear;
    logic [2*WIDTH-1:0]      out_data;
    logic [IDX_W-1:0]        out_idx;
    logic                    out_last;
    logic                    out_valid;
    logic                    out_ready;
    logic                    busy;
    logic                    overrun;

    int checks   = 0;
    int failures = 0;

    logic [15:0] a1 [N_PE];
    logic [15:0] a2 [N_PE];
    logic [15:0] exp_w [NW];

    pe_acc_drain #(.WIDTH(WIDTH), .N_PE(N_PE), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .acc1_bus(acc1_bus), .acc2_bus(acc2_bus),
        .pe_clear(pe_clear), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bus();
        for (int i = 0; i < N_PE; i++) begin
            acc1_bus[i*16 +: 16] = a1[i];
            acc2_bus[i*16 +: 16] = a2[i];
        end
    endtask

    task automatic load_random();
        for (int i = 0; i < N_PE; i++) begin
            a1[i] = 16'($urandom);
            a2[i] = 16'($urandom);
        end
        drive_bus();
    endtask

    // Reference: word j is acc1 (even j) or acc2 (odd j) of PE j/2 as seen at the accepting edge.
    task automatic model_snapshot();
        for (int j = 0; j < NW; j++)
            exp_w[j] = (j % 2 == 1) ? a2[j/2] : a1[j/2];
    endtask

    // Entered right after an accepted start; mode 0 ready=1, 1 pattern 1,0,0, 2 random.
    task automatic drain(input int mode);
        int j = 0;
        int cyc = 0;
        while (j < NW && cyc < 200) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            chk("valid", 32'(out_valid), 32'd1);
            chk("idx", 32'(out_idx), 32'(j));
            chk("data", 32'(out_data), 32'(exp_w[j]));
            chk("last", 32'(out_last), 32'(j == NW - 1));
            if (cyc > 0)
                chk("clear_once", 32'(pe_clear), 32'd0);
            if (mode != 0)
                load_random();
            tick();
            if (out_ready)
                j++;
            cyc++;
        end
        chk("drain_done", 32'(j), 32'(NW));
        chk("end_valid", 32'(out_valid), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_idx", 32'(out_idx), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        acc1_bus = '0;
        acc2_bus = '0;
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_clear", 32'(pe_clear), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Basic drain with snapshot isolation
        for (int i = 0; i < N_PE; i++) begin
            a1[i] = 16'h1000 + 16'(i);
            a2[i] = 16'h2000 + 16'(i);
        end
        drive_bus();
        model_snapshot();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("basic_clear", 32'(pe_clear), 32'd1);
        chk("basic_busy", 32'(busy), 32'd1);
        for (int i = 0; i < N_PE; i++) begin
            a1[i] = 16'hFFFF;
            a2[i] = 16'hFFFF;
        end
        drive_bus();
        drain(0);

        // Backpressure with random data
        load_random();
        model_snapshot();
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(1);

        // Dropped start at idx 3, back-to-back start on the last transfer
        load_random();
        model_snapshot();
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < NW; j++) begin
            chk("b2b_idx", 32'(out_idx), 32'(j));
            chk("b2b_data", 32'(out_data), 32'(exp_w[j]));
            chk("b2b_valid", 32'(out_valid), 32'd1);
            if (j == 3)
                start = 1'b1;
            if (j == NW - 1) begin
                for (int i = 0; i < N_PE; i++) begin
                    a1[i] = 16'hABCD;
                    a2[i] = 16'($urandom);
                end
                drive_bus();
                model_snapshot();
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (j == 3)
                chk("overrun_set", 32'(overrun), 32'd1);
        end
        chk("b2b_gap", 32'(out_valid), 32'd1);
        chk("b2b_idx0", 32'(out_idx), 32'd0);
        chk("b2b_word0", 32'(out_data), 32'h0000ABCD);
        chk("b2b_clear", 32'(pe_clear), 32'd1);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        drain(2);
        chk("overrun_kept", 32'(overrun), 32'd1);

        // Asynchronous reset at idx 5
        load_random();
        model_snapshot();
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        chk("pre_rst_idx", 32'(out_idx), 32'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_idx", 32'(out_idx), 32'd0);
        chk("arst_clear", 32'(pe_clear), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        load_random();
        model_snapshot();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fresh_clear", 32'(pe_clear), 32'd1);
        drain(2);

        // Start held for several cycles while stalled at idx 0
        out_ready = 1'b0;
        load_random();
        model_snapshot();
        start = 1'b1;
        tick();
        chk("held_first_ok", 32'(overrun), 32'd0);
        tick();
        start = 1'b0;
        chk("held_overrun", 32'(overrun), 32'd1);
        chk("held_idx", 32'(out_idx), 32'd0);
        load_random();
        drain(1);

        // Idle stability
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle_valid", 32'(out_valid), 32'd0);
            chk("idle_clear", 32'(pe_clear), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
